// File: rtl/cr_cddip_quiesce_ctrl.sv
// Quiesce controller: holds ISF intake, waits for the pipe to drain, then acks.
// Optional drain statistics enabled by defining CR_CDDIP_QUIESCE_STAT_EN.
package cr_cddip_quiesce_pkg;
    typedef struct packed {
        logic       isf_busy;
        logic       data_busy;
        logic       comp_busy;
        logic [7:0] isf_cmds;
        logic [7:0] pipe_cmds;
    } pipe_stat_t;

    typedef enum logic [2:0] {
        Q_RUN      = 3'd0,
        Q_HOLD     = 3'd1,
        Q_DRAIN    = 3'd2,
        Q_QUIESCED = 3'd3,
        Q_ERR      = 3'd4
    } q_state_e;
endpackage

module cr_cddip_quiesce_ctrl
    import cr_cddip_quiesce_pkg::*;
#(
    parameter int TMO_W       = 20,
    parameter int IDLE_STABLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_quiesce_req,
    input  logic [TMO_W-1:0] cfg_drain_tmo,
    input  pipe_stat_t       pipe_stat,
    input  logic             cddip_idle,
    input  logic             sup_osf_halt,
    output logic             sup_isf_hold,
    output logic             quiesce_ack,
    output logic [2:0]       quiesce_state,
    output logic [1:0]       quiesce_err,
    output logic [TMO_W-1:0] drain_cycles,
    output logic [TMO_W-1:0] drain_max
);

    localparam int SW = $clog2(IDLE_STABLE + 1);
    localparam logic [SW-1:0]    STABLE_LAST = SW'(IDLE_STABLE - 1);
    localparam logic [SW-1:0]    STABLE_ONE  = SW'(1);
    localparam logic [TMO_W-1:0] ONE         = TMO_W'(1);

    q_state_e         state_q, state_d;
    logic [TMO_W-1:0] timer_q, timer_d, timer_inc;
    logic [SW-1:0]    stable_q, stable_d;
    logic [1:0]       err_q, err_d;
    logic             hold_q, ack_q;
    logic             draining, idle, tmo_hit, done;
    logic             unused_isf_cmds;

    // Only zero-compares of the counters matter here; isf_cmds is informational.
    assign unused_isf_cmds = ^pipe_stat.isf_cmds;

    assign draining  = (state_q == Q_HOLD) || (state_q == Q_DRAIN);
    assign idle      = !pipe_stat.isf_busy && !pipe_stat.data_busy &&
                       !pipe_stat.comp_busy && cddip_idle &&
                       (pipe_stat.pipe_cmds == 8'd0);
    assign timer_inc = (&timer_q) ? timer_q : timer_q + ONE;
    assign tmo_hit   = draining && (cfg_drain_tmo != '0) &&
                       (timer_q == cfg_drain_tmo - ONE);
    assign done      = (state_q == Q_DRAIN) && idle && (stable_q == STABLE_LAST);

    // Next-state, timer, idle-stability counter and error flags.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        timer_d  = draining ? timer_inc : timer_q;
        stable_d = '0;
        if (state_q == Q_DRAIN && idle)
            stable_d = stable_q + STABLE_ONE;
        if (state_q != Q_RUN && !sw_quiesce_req) begin
            state_d = Q_RUN;
            err_d   = 2'b00;
        end else begin
            unique case (state_q)
                Q_RUN: begin
                    if (sw_quiesce_req) begin
                        state_d = Q_HOLD;
                        timer_d = '0;
                    end
                end
                Q_HOLD: begin
                    if (sup_osf_halt || tmo_hit) begin
                        state_d = Q_ERR;
                        err_d   = {sup_osf_halt, tmo_hit};
                    end else if (!pipe_stat.isf_busy) begin
                        state_d = Q_DRAIN;
                    end
                end
                Q_DRAIN: begin
                    if (sup_osf_halt || tmo_hit) begin
                        state_d = Q_ERR;
                        err_d   = {sup_osf_halt, tmo_hit};
                    end else if (done) begin
                        state_d = Q_QUIESCED;
                    end
                end
                Q_QUIESCED, Q_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = Q_RUN;
                    err_d   = 2'b00;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= Q_RUN;
            timer_q  <= '0;
            stable_q <= '0;
            err_q    <= 2'b00;
            hold_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            stable_q <= stable_d;
            err_q    <= err_d;
            hold_q   <= (state_d != Q_RUN);
            ack_q    <= (state_d == Q_QUIESCED);
        end
    end

    assign sup_isf_hold  = hold_q;
    assign quiesce_ack   = ack_q;
    assign quiesce_state = state_q;
    assign quiesce_err   = err_q;

`ifdef CR_CDDIP_QUIESCE_STAT_EN
    logic [TMO_W-1:0] dc_q, dmax_q;
    logic             q_entry;

    assign q_entry = (state_q == Q_DRAIN) && (state_d == Q_QUIESCED);

    // Capture drain length on each successful quiesce and track its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q   <= '0;
            dmax_q <= '0;
        end else if (q_entry) begin
            dc_q <= timer_inc;
            if (timer_inc > dmax_q)
                dmax_q <= timer_inc;
        end
    end

    assign drain_cycles = dc_q;
    assign drain_max    = dmax_q;
`else
    assign drain_cycles = '0;
    assign drain_max    = '0;
`endif

endmodule

// File: tb/tb_cr_cddip_quiesce_ctrl.sv
// Bench for cr_cddip_quiesce_ctrl: behavioural model, random and directed stimulus.
// Drain statistics expectations follow CR_CDDIP_QUIESCE_STAT_EN.
module tb_cr_cddip_quiesce_ctrl;
    import cr_cddip_quiesce_pkg::*;

    localparam int TMO_W       = 20;
    localparam int IDLE_STABLE = 4;
    localparam longint TMAX    = (longint'(1) << TMO_W) - 1;
`ifdef CR_CDDIP_QUIESCE_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic [TMO_W-1:0] tmo;
    pipe_stat_t       ps;
    logic             cidle;
    logic             halt;
    logic             hold, ack;
    logic [2:0]       qstate;
    logic [1:0]       qerr;
    logic [TMO_W-1:0] dc, dmax;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 run, 1 hold, 2 drain, 3 quiesced, 4 error.
    int         m_ph;
    longint     m_el;
    int         m_run;
    logic [1:0] m_err;
    longint     m_dc, m_dmax;

    cr_cddip_quiesce_ctrl #(.TMO_W(TMO_W), .IDLE_STABLE(IDLE_STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .sw_quiesce_req(req),
        .cfg_drain_tmo(tmo), .pipe_stat(ps), .cddip_idle(cidle),
        .sup_osf_halt(halt), .sup_isf_hold(hold), .quiesce_ack(ack),
        .quiesce_state(qstate), .quiesce_err(qerr),
        .drain_cycles(dc), .drain_max(dmax)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_run = 0; m_err = 2'b00; m_dc = 0; m_dmax = 0;
    endtask

    task automatic model_step();
        bit idle, tmo_hit, drn;
        idle = !ps.isf_busy && !ps.data_busy && !ps.comp_busy && cidle &&
               (ps.pipe_cmds == 8'd0);
        drn = (m_ph == 1) || (m_ph == 2);
        tmo_hit = drn && (tmo != '0) && (m_el == longint'(tmo) - 1);
        if (m_ph != 0 && !req) begin
            m_ph = 0; m_err = 2'b00;
        end else if (m_ph == 0) begin
            if (req) begin m_ph = 1; m_el = 0; m_run = 0; end
        end else if (drn) begin
            if (halt || tmo_hit) begin
                m_ph = 4; m_err = {halt, tmo_hit};
            end else if (m_ph == 1) begin
                if (!ps.isf_busy) m_ph = 2;
            end else begin
                m_run = idle ? m_run + 1 : 0;
                if (m_run == IDLE_STABLE) begin
                    m_ph = 3;
                    m_dc = (m_el + 1 > TMAX) ? TMAX : m_el + 1;
                    if (m_dc > m_dmax) m_dmax = m_dc;
                end
            end
            if (m_ph == 1 || m_ph == 2)
                m_el = (m_el + 1 > TMAX) ? TMAX : m_el + 1;
        end
    endtask

    task automatic cmp_all();
        chk("state", qstate, m_ph);
        chk("hold", hold, (m_ph != 0) ? 1 : 0);
        chk("ack", ack, (m_ph == 3) ? 1 : 0);
        chk("err", qerr, m_err);
        chk("drain_cycles", dc, STAT_EN ? m_dc : 0);
        chk("drain_max", dmax, STAT_EN ? m_dmax : 0);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic run_drain(input int n);
        req = 1'b1; ps.data_busy = 1'b1;
        repeat (n - 3) cyc();
        ps.data_busy = 1'b0;
        repeat (4) cyc();
        chk("stat_ack", ack, 1);
        req = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; tmo = '0; ps = '0; cidle = 1'b1; halt = 1'b0;
        model_reset();
        #1;
        chk("rst_state", qstate, 0);
        chk("rst_hold", hold, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", qerr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Empty pipe: hold @1, DRAIN @2, ack @6.
        req = 1'b1;
        cyc(); chk("t1_hold1", hold, 1); chk("t1_state1", qstate, 1);
        cyc(); chk("t1_state2", qstate, 2);
        repeat (3) cyc(); chk("t1_ack5", ack, 0);
        cyc(); chk("t1_ack6", ack, 1); chk("t1_dc", dc, STAT_EN ? 5 : 0);
        req = 1'b0;
        cyc(); chk("t1_rel_state", qstate, 0); chk("t1_rel_hold", hold, 0);

        // Drain timeout of 50 cycles.
        tmo = TMO_W'(50); ps.data_busy = 1'b1; req = 1'b1;
        repeat (50) cyc(); chk("t2_state50", qstate, 2);
        cyc(); chk("t2_state51", qstate, 4); chk("t2_err", qerr, 1);
        chk("t2_hold", hold, 1);
        req = 1'b0;
        cyc(); chk("t2_rel_state", qstate, 0); chk("t2_rel_err", qerr, 0);
        chk("t2_rel_hold", hold, 0);
        tmo = '0;

        // Halt during DRAIN.
        req = 1'b1;
        repeat (4) cyc();
        halt = 1'b1; cyc(); chk("t3_state", qstate, 4); chk("t3_err", qerr, 2);
        halt = 1'b0; cyc(); chk("t3_sticky", qerr, 2);
        req = 1'b0; cyc();

        // Busy until cycle 20, then halt while QUIESCED.
        ps.data_busy = 1'b1; ps.pipe_cmds = 8'd3; req = 1'b1;
        repeat (20) cyc();
        ps.data_busy = 1'b0; ps.pipe_cmds = 8'd0;
        repeat (3) cyc(); chk("t4_ack23", ack, 0);
        cyc(); chk("t4_ack24", ack, 1); chk("t4_dc", dc, STAT_EN ? 23 : 0);
        halt = 1'b1; cyc(); chk("t4_halt_ack", ack, 1); chk("t4_halt_st", qstate, 3);
        halt = 1'b0; req = 1'b0; cyc();

        // Glitch at stable count 3 delays ack by 4.
        req = 1'b1;
        repeat (5) cyc();
        ps.data_busy = 1'b1; cyc();
        ps.data_busy = 1'b0;
        repeat (3) cyc(); chk("t4g_ack9", ack, 0);
        cyc(); chk("t4g_ack10", ack, 1); chk("t4g_dc", dc, STAT_EN ? 9 : 0);
        req = 1'b0; cyc();

        // Abort mid-DRAIN leaves stats alone.
        ps.data_busy = 1'b1; req = 1'b1;
        repeat (5) cyc();
        req = 1'b0;
        cyc(); chk("t5_state", qstate, 0); chk("t5_err", qerr, 0);
        chk("t5_dc", dc, STAT_EN ? 9 : 0);
        ps.data_busy = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            ps.isf_busy  = ($urandom % 4 == 0);
            ps.data_busy = ($urandom % 3 == 0);
            ps.comp_busy = ($urandom % 6 == 0);
            ps.isf_cmds  = 8'($urandom);
            ps.pipe_cmds = ($urandom % 5 == 0) ? 8'($urandom) : 8'd0;
            cidle        = ($urandom % 8 != 0);
            halt         = ($urandom % 80 == 0);
            if ($urandom % 100 == 0)
                tmo = ($urandom % 3 == 0) ? '0 : TMO_W'($urandom_range(6, 40));
            if (m_ph == 0) req = ($urandom % 3 != 0);
            else           req = ($urandom % 50 != 0);
            cyc();
        end
        ps = '0; cidle = 1'b1; halt = 1'b0; tmo = '0;
        req = 1'b0; cyc();

        // Asynchronous reset mid-DRAIN.
        ps.data_busy = 1'b1; req = 1'b1;
        repeat (5) cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_state", qstate, 0); chk("t6_hold", hold, 0);
        chk("t6_ack", ack, 0); chk("t6_err", qerr, 0);
        chk("t6_dc", dc, 0); chk("t6_dmax", dmax, 0);
        req = 1'b0; ps.data_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Drain statistics over three quiesces.
        run_drain(10);
        run_drain(30);
        run_drain(20);
        chk("t7_dc", dc, STAT_EN ? 20 : 0);
        chk("t7_dmax", dmax, STAT_EN ? 30 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
